mem_port_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory between the multicycle control path and a DMA/IO requester.
- CPU side:
  - Takes the control unit's MemRead/MemWrite strobes with the IorD-muxed address.
  - Returns `cpu_stall` so the control FSM holds its current state while it loses arbitration.
- Arbitration: fixed priority to the CPU, with a starvation counter and a bounded DMA lock for read-modify-write.
- Sits between the datapath memory mux and the memory macro.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_arb_fairness.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the memory port arbiter
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_OWN = 2'd1,
      DMA_OWN = 2'd2
   } state_e;

   localparam int MEM_RD_LAT = 1;

   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? lim : v + 4'd1;
   endfunction

endpackage

// File: rtl/mem_arb_fairness.sv
// rtl/mem_arb_fairness.sv - DMA starvation counter and bounded lock tracking
module mem_arb_fairness
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4,
   parameter int MAX_LOCK = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic dma_req,
   input  logic dma_lock,
   input  logic dma_own,
   input  logic dma_gnt,
   input  logic cpu_gnt,
   output logic force_dma,
   output logic lock_active
);

   localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
   localparam logic [3:0] LOCK_LIM = 4'(MAX_LOCK);

   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic [3:0] lock_cnt_q, lock_cnt_d;
   logic       lock_held_q, lock_held_d;

   always_comb begin
      wait_cnt_d = '0;
      if (dma_req && cpu_gnt)
         wait_cnt_d = sat_inc(wait_cnt_q, WAIT_LIM);
      // A saturated lock count stays saturated until a non-locked grant, a CPU grant or an idle cycle
      lock_cnt_d = '0;
      if (dma_gnt && dma_lock)
         lock_cnt_d = sat_inc(lock_cnt_q, LOCK_LIM);
      lock_held_d = lock_held_q;
      if (dma_gnt)
         lock_held_d = dma_lock;
   end

   assign force_dma   = dma_req & (wait_cnt_q == WAIT_LIM);
   assign lock_active = dma_req & dma_own & lock_held_q & (lock_cnt_q < LOCK_LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q  <= '0;
         lock_cnt_q  <= '0;
         lock_held_q <= 1'b0;
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         lock_cnt_q  <= lock_cnt_d;
         lock_held_q <= lock_held_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/DMA arbiter in front of the unified single-port memory
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int MAX_WAIT = 4,
   parameter int MAX_LOCK = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic          dma_lock,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          err
);

   state_e        state_q, state_d;
   owner_e        rd_pipe_q [MEM_RD_LAT];
   owner_e        rd_pipe_d [MEM_RD_LAT];
   owner_e        rd_owner;
   logic [DW-1:0] cpu_hold_q, cpu_hold_d;
   logic [DW-1:0] dma_hold_q, dma_hold_d;
   logic          err_q, err_d;
   logic          cpu_req, dma_req_v;
   logic          win_cpu, win_dma;
   logic          force_dma, lock_active;

   // Requests are masked during reset so every output reads zero while rst_n is low
   assign cpu_req   = (cpu_rd | cpu_wr) & rst_n;
   assign dma_req_v = dma_req & rst_n;

   mem_arb_fairness #(
      .MAX_WAIT (MAX_WAIT),
      .MAX_LOCK (MAX_LOCK)
   ) u_fairness (
      .clk         (clk),
      .rst_n       (rst_n),
      .dma_req     (dma_req_v),
      .dma_lock    (dma_lock),
      .dma_own     (state_q == DMA_OWN),
      .dma_gnt     (win_dma),
      .cpu_gnt     (win_cpu),
      .force_dma   (force_dma),
      .lock_active (lock_active)
   );

   always_comb begin
      win_dma   = lock_active | force_dma | (dma_req_v & ~cpu_req);
      win_cpu   = cpu_req & ~win_dma;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (win_cpu) begin
         mem_we    = cpu_wr;
         mem_re    = cpu_rd & ~cpu_wr;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (win_dma) begin
         mem_we    = dma_we;
         mem_re    = ~dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end
      dma_gnt   = win_dma;
      cpu_stall = cpu_req & ~win_cpu;

      state_d = IDLE;
      if (win_cpu)
         state_d = CPU_OWN;
      else if (win_dma)
         state_d = DMA_OWN;

      // Track who issued each read so the returning data lands on the right port
      rd_pipe_d[0] = OWN_NONE;
      if (mem_re)
         rd_pipe_d[0] = win_cpu ? OWN_CPU : OWN_DMA;
      for (int i = 1; i < MEM_RD_LAT; i++)
         rd_pipe_d[i] = rd_pipe_q[i-1];
      rd_owner = rd_pipe_q[MEM_RD_LAT-1];

      cpu_rdata  = (rd_owner == OWN_CPU) ? mem_rdata : cpu_hold_q;
      dma_rdata  = (rd_owner == OWN_DMA) ? mem_rdata : dma_hold_q;
      dma_rvalid = (rd_owner == OWN_DMA);
      cpu_hold_d = cpu_rdata;
      dma_hold_d = dma_rdata;

      err_d = err_q | (cpu_rd & cpu_wr);
      err   = err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cpu_hold_q <= '0;
         dma_hold_q <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < MEM_RD_LAT; i++)
            rd_pipe_q[i] <= OWN_NONE;
      end else begin
         state_q    <= state_d;
         cpu_hold_q <= cpu_hold_d;
         dma_hold_q <= dma_hold_d;
         err_q      <= err_d;
         for (int i = 0; i < MEM_RD_LAT; i++)
            rd_pipe_q[i] <= rd_pipe_d[i];
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks against a rule-level arbiter model
module tb_mem_port_arbiter;

   localparam int AW       = 16;
   localparam int DW       = 16;
   localparam int MAX_WAIT = 4;
   localparam int MAX_LOCK = 3;

   logic          clk;
   logic          rst_n;
   logic          cpu_rd, cpu_wr;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          cpu_stall;
   logic          dma_req, dma_we, dma_lock;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata, dma_rdata;
   logic          dma_gnt, dma_rvalid;
   logic          mem_re, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          err;

   bit [15:0] macro  [65536];
   bit [15:0] shadow [65536];

   int checks = 0;
   int errors = 0;

   int          m_wait, m_run, m_last, m_pend;
   logic        m_lastlock, m_err;
   logic [15:0] m_pend_data, m_cpu_hold, m_dma_hold;

   logic        last_gnt, last_stall, last_we, last_rvalid;
   logic [15:0] last_drdata;

   mem_port_arbiter #(
      .AW (AW), .DW (DW), .MAX_WAIT (MAX_WAIT), .MAX_LOCK (MAX_LOCK)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_rd     (cpu_rd),
      .cpu_wr     (cpu_wr),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_lock   (dma_lock),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial mem_rdata = '0;
   always @(posedge clk) begin
      if (mem_we) macro[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= macro[mem_addr];
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wait = 0; m_run = 0; m_last = 0; m_pend = 0;
      m_lastlock = 1'b0; m_err = 1'b0;
      m_pend_data = '0; m_cpu_hold = '0; m_dma_hold = '0;
   endtask

   task automatic set_idle();
      cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".cpu_rdata"}, cpu_rdata, 0);
      chk({tag, ".cpu_stall"}, cpu_stall, 0);
      chk({tag, ".dma_gnt"}, dma_gnt, 0);
      chk({tag, ".dma_rvalid"}, dma_rvalid, 0);
      chk({tag, ".dma_rdata"}, dma_rdata, 0);
      chk({tag, ".mem_re"}, mem_re, 0);
      chk({tag, ".mem_we"}, mem_we, 0);
      chk({tag, ".mem_addr"}, mem_addr, 0);
      chk({tag, ".mem_wdata"}, mem_wdata, 0);
      chk({tag, ".err"}, err, 0);
   endtask

   // Entered just after a falling edge with inputs applied; leaves at the next falling edge
   task automatic cycle(input string tag);
      int          win;
      logic        creq, e_re, e_we;
      logic [15:0] e_addr, e_wd;
      #1;
      creq = cpu_rd | cpu_wr;
      if (dma_req && m_last == 2 && m_lastlock && m_run < MAX_LOCK) win = 2;
      else if (dma_req && m_wait == MAX_WAIT)                      win = 2;
      else if (creq)                                               win = 1;
      else if (dma_req)                                            win = 2;
      else                                                         win = 0;
      e_re = 0; e_we = 0; e_addr = '0; e_wd = '0;
      if (win == 1) begin
         e_we = cpu_wr; e_re = cpu_rd & ~cpu_wr; e_addr = cpu_addr; e_wd = cpu_wdata;
      end else if (win == 2) begin
         e_we = dma_we; e_re = ~dma_we; e_addr = dma_addr; e_wd = dma_wdata;
      end
      last_gnt = dma_gnt; last_stall = cpu_stall; last_we = mem_we;
      last_rvalid = dma_rvalid; last_drdata = dma_rdata;
      chk({tag, ".dma_gnt"}, dma_gnt, (win == 2));
      chk({tag, ".cpu_stall"}, cpu_stall, (creq && win != 1));
      chk({tag, ".mem_re"}, mem_re, e_re);
      chk({tag, ".mem_we"}, mem_we, e_we);
      chk({tag, ".mem_addr"}, mem_addr, e_addr);
      chk({tag, ".mem_wdata"}, mem_wdata, e_wd);
      chk({tag, ".dma_rvalid"}, dma_rvalid, (m_pend == 2));
      if (m_pend == 2) chk({tag, ".dma_rdata"}, dma_rdata, m_pend_data);
      chk({tag, ".cpu_rdata"}, cpu_rdata, (m_pend == 1) ? m_pend_data : m_cpu_hold);
      chk({tag, ".err"}, err, m_err);
      @(posedge clk);
      if (m_pend == 1) m_cpu_hold = m_pend_data;
      if (m_pend == 2) m_dma_hold = m_pend_data;
      m_pend = 0;
      if (e_re) begin
         m_pend = win;
         m_pend_data = shadow[e_addr];
      end
      if (e_we) shadow[e_addr] = e_wd;
      m_wait = (win == 1 && dma_req) ? ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
      m_run  = (win == 2 && dma_lock) ? ((m_run + 1 > MAX_LOCK) ? MAX_LOCK : m_run + 1) : 0;
      if (win == 2) m_lastlock = dma_lock;
      m_last = win;
      if (cpu_rd && cpu_wr) m_err = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic        gnts [16];
      logic        stls [16];
      int          k;
      logic        granted;
      int          r;
      for (int i = 0; i < 65536; i++) begin
         macro[i]  = 16'($urandom);
         shadow[i] = macro[i];
      end
      macro[16'h0010] = 16'hBEEF; shadow[16'h0010] = 16'hBEEF;
      macro[16'h0020] = 16'h00AA; shadow[16'h0020] = 16'h00AA;
      macro[16'h0021] = 16'h00BB; shadow[16'h0021] = 16'h00BB;
      rst_n = 1'b0;
      set_idle();
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // CPU read alone
      cpu_rd = 1; cpu_addr = 16'h0010;
      cycle("cpu_rd");
      set_idle();
      cycle("cpu_rd_ret");
      chk("cpu_rdata_beef", cpu_rdata, 16'hBEEF);

      // starvation pattern
      cpu_rd = 1; cpu_addr = 16'h0011;
      dma_req = 1; dma_addr = 16'h0040;
      for (int i = 0; i < 10; i++) begin
         cycle("starve");
         chk("starve_pattern", last_gnt, ((i % 5) == 4));
      end
      set_idle();
      cycle("idle0");

      // locked read-modify-write with a CPU write pending
      cpu_wr = 1; cpu_addr = 16'h0200; cpu_wdata = 16'h5555;
      dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 16'h0100;
      granted = 0;
      for (int i = 0; i < 10 && !granted; i++) begin
         cycle("rmw_rd");
         granted = last_gnt;
      end
      chk("rmw_rd_granted", granted, 1);
      dma_we = 1; dma_wdata = 16'h1234; dma_lock = 0;
      cycle("rmw_wr");
      chk("rmw_consecutive", last_gnt, 1);
      chk("rmw_cpu_stalled", last_stall, 1);
      dma_req = 0; dma_we = 0;
      cycle("rmw_cpu");
      chk("rmw_mem", macro[16'h0100], 16'h1234);
      set_idle();
      cycle("idle1");

      // lock bound
      cpu_rd = 1; cpu_addr = 16'h0012;
      dma_req = 1; dma_lock = 1; dma_we = 0;
      for (int i = 0; i < 16; i++) begin
         dma_addr = 16'(16'h0300 + i);
         cycle("lockb");
         gnts[i] = last_gnt;
         stls[i] = last_stall;
      end
      k = -1;
      for (int i = 0; i < 13; i++)
         if (k < 0 && gnts[i]) k = i;
      chk("lockb_found", (k >= 0), 1);
      if (k >= 0) begin
         chk("lockb_g2", gnts[k+1], 1);
         chk("lockb_g3", gnts[k+2], 1);
         chk("lockb_cpu_gnt", gnts[k+3], 0);
         chk("lockb_cpu_nostall", stls[k+3], 0);
      end
      set_idle();
      cycle("idle2");

      // interleaved reads
      dma_req = 1; dma_addr = 16'h0020;
      cycle("il_dma");
      set_idle();
      cpu_rd = 1; cpu_addr = 16'h0021;
      cycle("il_cpu");
      chk("il_dma_rvalid", last_rvalid, 1);
      chk("il_dma_rdata", last_drdata, 16'h00AA);
      set_idle();
      cycle("il_tail");
      chk("il_cpu_rdata", cpu_rdata, 16'h00BB);

      // simultaneous rd/wr
      cpu_rd = 1; cpu_wr = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h7777;
      cycle("err_issue");
      chk("err_we", last_we, 1);
      set_idle();
      cycle("err_idle");
      chk("err_set", err, 1);
      repeat (3) cycle("err_hold");
      chk("err_held", err, 1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 7));
         cpu_rd    = (r == 1 || r == 2 || r == 7);
         cpu_wr    = (r == 3 || r == 4 || r == 7);
         cpu_addr  = 16'($urandom_range(0, 15));
         cpu_wdata = 16'($urandom);
         dma_req   = 1'($urandom_range(0, 1));
         dma_we    = 1'($urandom_range(0, 1));
         dma_lock  = ($urandom_range(0, 3) != 0);
         dma_addr  = 16'($urandom_range(0, 15));
         dma_wdata = 16'($urandom);
         cycle("rand");
      end

      // reset with a DMA read in flight
      set_idle();
      cycle("pre_rst_idle");
      dma_req = 1; dma_addr = 16'h0020;
      cycle("pre_rst_rd");
      set_idle();
      rst_n = 1'b0;
      #1;
      check_zero("mid_reset");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      cycle("post_rst");
      chk("post_rst_rvalid", last_rvalid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
